// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and the ALU control decode function for
// the EX-stage ALU control with iterative multiplier.
package alu_ctrl_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_OR    = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    localparam logic [2:0] ALUCTRL_AND = 3'b000;
    localparam logic [2:0] ALUCTRL_OR  = 3'b001;
    localparam logic [2:0] ALUCTRL_ADD = 3'b010;
    localparam logic [2:0] ALUCTRL_BAD = 3'b100;
    localparam logic [2:0] ALUCTRL_SUB = 3'b110;
    localparam logic [2:0] ALUCTRL_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] funct);
        logic [2:0] code;
        code = ALUCTRL_BAD;
        case (aluop)
            ALUOP_OR:  code = ALUCTRL_OR;
            ALUOP_ADD: code = ALUCTRL_ADD;
            ALUOP_SUB: code = ALUCTRL_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: code = ALUCTRL_ADD;
                    FUNCT_SUB: code = ALUCTRL_SUB;
                    FUNCT_MUL: code = ALUCTRL_MUL;
                    FUNCT_AND: code = ALUCTRL_AND;
                    FUNCT_OR:  code = ALUCTRL_OR;
                    default:   code = ALUCTRL_BAD;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_mc_mul_iter_core.sv
// Shift-add multiplier datapath: one multiplier bit per step, with an
// optional early finish once the remaining multiplier bits are all zero.
module mul_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0,
    parameter int CNT_W      = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] acc_nxt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mplier_shr;

    always_comb begin
        acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr = mplier_q >> 1;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shr;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // The current step is the final one when the counter reaches its last
    // value, or (early mode) when no set multiplier bits remain after it.
    assign last_o    = (cnt_q == CNT_W'(WIDTH - 1)) ||
                       ((EARLY_TERM != 0) && (mplier_shr == '0));
    assign acc_nxt_o = acc_step;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// EX-stage ALU control: combinational funct/ALUOp decode plus a multi-cycle
// multiply sequencer that stalls the pipeline until the product is ready.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [5:0]       funct_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [2:0]       ALUCtrl_o,
    output logic             illegal_o,
    output logic             stall_o,
    output logic             mul_valid_o,
    output logic [WIDTH-1:0] mul_result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             mul_req;
    logic             start;
    logic             step;
    logic             stall;
    logic             mul_valid;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;

    assign ALUCtrl_o = alu_decode(ALUOp_i, funct_i);
    assign illegal_o = valid_i && (ALUOp_i == ALUOP_RTYPE) && (ALUCtrl_o == ALUCTRL_BAD);
    assign mul_req   = valid_i && (ALUOp_i == ALUOP_RTYPE) && (funct_i == FUNCT_MUL);

    mul_iter_core #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM),
        .CNT_W      (CNT_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start),
        .step_i    (step),
        .mcand_i   (data1_i),
        .mplier_i  (data2_i),
        .acc_nxt_o (acc_nxt),
        .last_o    (last)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        start     = 1'b0;
        step      = 1'b0;
        stall     = 1'b0;
        mul_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mul_req && !flush_i) begin
                    start   = 1'b1;
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    step  = 1'b1;
                    if (last) begin
                        result_d = acc_nxt;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The instruction still sitting in EX is the one just finished.
                mul_valid = !flush_i;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall is forced low for the whole reset window, not just from IDLE.
    assign stall_o      = stall && rst_i;
    assign mul_valid_o  = mul_valid;
    assign mul_result_o = result_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc: one fixed-length and one early-terminating
// instance share the operand/decode inputs but have separate valid lines.
module tb_alu_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, valid_b, flush;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic [31:0] d1, d2;

    logic [2:0]  ctrl_a, ctrl_b;
    logic        ill_a, ill_b, stall_a, stall_b, mv_a, mv_b;
    logic [31:0] res_a, res_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_ctrl_mc #(.WIDTH(32), .EARLY_TERM(0)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_a), .flush_i(flush),
        .funct_i(funct), .ALUOp_i(aluop), .data1_i(d1), .data2_i(d2),
        .ALUCtrl_o(ctrl_a), .illegal_o(ill_a), .stall_o(stall_a),
        .mul_valid_o(mv_a), .mul_result_o(res_a)
    );

    alu_ctrl_mc #(.WIDTH(32), .EARLY_TERM(1)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid_b), .flush_i(flush),
        .funct_i(funct), .ALUOp_i(aluop), .data1_i(d1), .data2_i(d2),
        .ALUCtrl_o(ctrl_b), .illegal_o(ill_b), .stall_o(stall_b),
        .mul_valid_o(mv_b), .mul_result_o(res_b)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Counts stalled cycles starting with the current one, then checks the
    // DONE cycle that follows.
    task automatic measure(input bit sel, input int exp_n, input logic [31:0] exp_res,
                           input string tag);
        int n = 0;
        while (((sel ? stall_b : stall_a) === 1'b1) && n < 200) begin
            n++;
            cyc();
            #1;
        end
        chk(n, exp_n, {tag, "_stall_cycles"});
        chk({31'd0, sel ? mv_b : mv_a}, 32'd1, {tag, "_valid"});
        chk(sel ? res_b : res_a, exp_res, {tag, "_result"});
        chk({31'd0, sel ? stall_b : stall_a}, 32'd0, {tag, "_done_stall"});
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] fn, input logic v,
                       input logic [2:0] exp_ctrl, input logic exp_ill, input string tag);
        aluop   = op;
        funct   = fn;
        valid_a = v;
        #1;
        chk({29'd0, ctrl_a}, {29'd0, exp_ctrl}, {tag, "_ctrl"});
        chk({31'd0, ill_a}, {31'd0, exp_ill}, {tag, "_illegal"});
        chk({31'd0, stall_a}, 32'd0, {tag, "_stall"});
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        flush   = 1'b0;
        funct   = 6'b011000;
        aluop   = 2'b00;
        d1      = 32'd7;
        d2      = 32'd6;
        #3;
        chk({31'd0, stall_a}, 32'd0, "rst_stall_a");
        chk({31'd0, stall_b}, 32'd0, "rst_stall_b");
        chk({31'd0, mv_a}, 32'd0, "rst_valid_a");
        chk(res_a, 32'd0, "rst_result_a");
        valid_a = 1'b0;
        valid_b = 1'b0;
        #9;
        rst_n = 1'b1;
        #1;

        dec(2'b00, 6'b100010, 1'b1, 3'b110, 1'b0, "dec_sub");
        dec(2'b00, 6'b000000, 1'b1, 3'b100, 1'b1, "dec_bad");
        dec(2'b00, 6'b100000, 1'b1, 3'b010, 1'b0, "dec_add");
        dec(2'b00, 6'b100100, 1'b1, 3'b000, 1'b0, "dec_and");
        dec(2'b00, 6'b100101, 1'b1, 3'b001, 1'b0, "dec_or");
        dec(2'b01, 6'b000000, 1'b1, 3'b001, 1'b0, "dec_op01");
        dec(2'b10, 6'b000000, 1'b1, 3'b010, 1'b0, "dec_op10");
        dec(2'b11, 6'b100000, 1'b1, 3'b110, 1'b0, "dec_op11");
        dec(2'b00, 6'b000000, 1'b0, 3'b100, 1'b0, "dec_bad_novalid");
        valid_a = 1'b0;
        cyc();

        // fixed-length multiply 7*6
        funct   = 6'b011000;
        aluop   = 2'b00;
        d1      = 32'd7;
        d2      = 32'd6;
        valid_a = 1'b1;
        #1;
        chk({29'd0, ctrl_a}, 32'd7, "dec_mul_ctrl");
        measure(1'b0, 33, 32'd42, "mul7x6");
        valid_a = 1'b0;
        cyc();
        #1;
        chk({31'd0, mv_a}, 32'd0, "mul7x6_pulse_end");
        chk(res_a, 32'd42, "mul7x6_hold");
        chk({31'd0, stall_a}, 32'd0, "mul7x6_idle_stall");

        // early termination
        d1      = 32'hFFFF_FFFF;
        d2      = 32'd3;
        valid_b = 1'b1;
        #1;
        measure(1'b1, 3, 32'hFFFF_FFFD, "et_ffx3");
        d2 = 32'd0;
        cyc();
        #1;
        measure(1'b1, 2, 32'd0, "et_x0");
        valid_b = 1'b0;
        cyc();
        #1;
        chk({31'd0, mv_b}, 32'd0, "et_pulse_end");

        // flush in BUSY cycle 5, then an immediate new multiply
        d1      = 32'd7;
        d2      = 32'd6;
        valid_a = 1'b1;
        #1;
        chk({31'd0, stall_a}, 32'd1, "flush_issue");
        repeat (5) cyc();
        flush = 1'b1;
        #1;
        chk({31'd0, stall_a}, 32'd0, "flush_stall");
        chk({31'd0, mv_a}, 32'd0, "flush_valid");
        chk(res_a, 32'd42, "flush_result");
        cyc();
        flush = 1'b0;
        d1    = 32'd5;
        d2    = 32'd5;
        #1;
        chk({31'd0, mv_a}, 32'd0, "flush_no_pulse");
        measure(1'b0, 33, 32'd25, "mul5x5");
        valid_a = 1'b0;
        cyc();

        // back-to-back multiplies
        d1      = 32'd3;
        d2      = 32'd4;
        valid_a = 1'b1;
        #1;
        measure(1'b0, 33, 32'd12, "b2b_3x4");
        d1 = 32'd2;
        d2 = 32'd8;
        cyc();
        #1;
        chk({31'd0, stall_a}, 32'd1, "b2b_gap");
        chk(res_a, 32'd12, "b2b_hold");
        measure(1'b0, 33, 32'd16, "b2b_2x8");
        valid_a = 1'b0;
        cyc();

        // asynchronous reset in BUSY cycle 10
        d1      = 32'd9;
        d2      = 32'd7;
        valid_a = 1'b1;
        #1;
        repeat (10) cyc();
        #1;
        rst_n = 1'b0;
        #1;
        chk({31'd0, stall_a}, 32'd0, "arst_stall");
        chk({31'd0, mv_a}, 32'd0, "arst_valid");
        chk(res_a, 32'd0, "arst_result");
        #1;
        rst_n = 1'b1;
        #1;
        chk({31'd0, stall_a}, 32'd1, "post_rst_issue");
        measure(1'b0, 33, 32'd63, "mul9x7_after_rst");
        valid_a = 1'b0;
        cyc();
        #1;
        chk(res_a, 32'd63, "mul9x7_hold");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
